// File: rtl/alu_uart_pkg.sv
// Shared state encoding and ALU opcode constants for the ALU/UART frame controller.
package alu_uart_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SEND = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/alu_uart_interface_frame_timer.sv
// Inter-byte timeout: down-counter reloaded on clr or while disabled; expire flags terminal count.
module frame_timer #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int TO_BITS     = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_BITS-1:0] LOAD = TO_BITS'(TIMEOUT_CYC - 1);

    logic [TO_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TO_BITS'(1);
        end
    end

    assign expire = en && !clr && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_interface.sv
// Frame controller: pops A, B, opcode from the RX FIFO, registers ALU inputs, pushes the result.
// Optional inter-byte timeout is built when ALU_IF_TIMEOUT_EN is defined.
//
// state  | meaning
// S_A    | idle, waiting for operand A byte
// S_B    | waiting for operand B byte
// S_OP   | waiting for opcode byte
// S_EXEC | ALU inputs stable for one cycle, result captured at the end
// S_SEND | waiting for room in the TX FIFO
module alu_uart_interface
    import alu_uart_pkg::*;
#(
    parameter int DBIT        = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int TO_BITS     = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    input  logic [DBIT-1:0]  alu_result,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout
);

    state_t            state_q, state_d;
    logic [DBIT-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [NB_OP-1:0]  op_q, op_d;
    logic              expire;

`ifdef ALU_IF_TIMEOUT_EN
    logic waiting;
    assign waiting = (state_q == S_B) || (state_q == S_OP);

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_BITS     (TO_BITS)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (rd_uart),
        .en     (waiting),
        .expire (expire)
    );
`else
    localparam logic [TO_BITS-1:0] TO_LOAD = TO_BITS'(TIMEOUT_CYC - 1);
    logic unused_to;
    assign unused_to = ^TO_LOAD;
    assign expire    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_A: begin
                if (!rx_empty) begin
                    a_d     = r_data;
                    rd_uart = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (!rx_empty) begin
                    b_d     = r_data;
                    rd_uart = 1'b1;
                    state_d = S_OP;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_A;
                end
            end
            S_OP: begin
                if (!rx_empty) begin
                    op_d    = r_data[NB_OP-1:0];
                    rd_uart = 1'b1;
                    state_d = S_EXEC;
                end else if (expire) begin
                    timeout = 1'b1;
                    state_d = S_A;
                end
            end
            S_EXEC: begin
                res_d   = alu_result;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
        // FIFO strobes must never fire in a reset cycle, whatever the stale state says.
        if (reset) begin
            rd_uart = 1'b0;
            wr_uart = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign frame_done = wr_uart;
    assign busy       = (state_q != S_A);
    assign w_data     = res_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Self-checking bench for alu_uart_interface: queue-based RX FIFO, behavioural ALU, result scoreboard.
module tb_alu_uart_interface;
    import alu_uart_pkg::*;

    localparam int TCYC = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'hA5;
    logic       tx_full = 1'b0;
    logic       rd_uart, wr_uart, busy, frame_done, timeout;
    logic [7:0] w_data, alu_a, alu_b, alu_result;
    logic [5:0] alu_op;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] rxq[$];
    int         rd_cyc[$], wr_cyc[$], to_cyc[$];
    logic [7:0] wr_dat[$];
    logic       do_pop;

    alu_uart_interface #(
        .DBIT(8), .NB_OP(6), .TIMEOUT_CYC(TCYC), .TO_BITS(8)
    ) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .frame_done(frame_done), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return 8'($signed(a) >>> b);
            OP_SRL:  return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic refresh();
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'hA5 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Show-ahead FIFO: a pop seen in a cycle takes effect just after the next edge.
    always begin
        @(negedge clk);
        do_pop = rd_uart;
        @(posedge clk);
        #1;
        if (do_pop && rxq.size() > 0) void'(rxq.pop_front());
        refresh();
    end

    always @(negedge clk) begin
        if (rd_uart || wr_uart || frame_done) begin
            checks++;
            if (rd_uart && wr_uart) begin
                errors++;
                $display("FAIL rd_wr_exclusive: cycle %0d got rd=1 wr=1 expected not both", cyc);
            end
            checks++;
            if (frame_done !== wr_uart) begin
                errors++;
                $display("FAIL frame_done_coincident: cycle %0d got %b expected %b", cyc, frame_done, wr_uart);
            end
        end
        if (rd_uart) rd_cyc.push_back(cyc);
        if (wr_uart) begin
            wr_cyc.push_back(cyc);
            wr_dat.push_back(w_data);
        end
        if (timeout) to_cyc.push_back(cyc);
    end

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (wr_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (wr_cyc.size() < n) begin
            errors++;
            $display("FAIL %s_wait: got %0d writes expected %0d", name, wr_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({rd_uart, wr_uart, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 000", {rd_uart, wr_uart, timeout});
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op, w_data} !== 30'h0) begin
            errors++;
            $display("FAIL reset_regs: got a=%h b=%h op=%h w=%h expected 0", alu_a, alu_b, alu_op, w_data);
        end
        checks++;
        if ({busy, frame_done, rd_uart, wr_uart, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {busy, frame_done, rd_uart, wr_uart, timeout});
        end
    endtask

    task automatic test_single_add();
        int n0 = rd_cyc.size();
        int w0 = wr_cyc.size();
        tick();
        push(8'h05); push(8'h03); push(8'h20);
        wait_writes(w0 + 1, 40, "single");
        checks++;
        if (rd_cyc.size() - n0 != 3) begin
            errors++;
            $display("FAIL single_rd_count: got %0d expected 3", rd_cyc.size() - n0);
        end else begin
            checks++;
            if (rd_cyc[n0+1] != rd_cyc[n0] + 1 || rd_cyc[n0+2] != rd_cyc[n0] + 2) begin
                errors++;
                $display("FAIL single_rd_consecutive: got %0d %0d %0d", rd_cyc[n0], rd_cyc[n0+1], rd_cyc[n0+2]);
            end
            if (wr_cyc.size() > w0) begin
                checks++;
                if (wr_cyc[w0] != rd_cyc[n0] + 4) begin
                    errors++;
                    $display("FAIL single_latency: got write at %0d expected %0d", wr_cyc[w0], rd_cyc[n0] + 4);
                end
            end
        end
        if (wr_dat.size() > w0) begin
            checks++;
            if (wr_dat[w0] !== 8'h08) begin
                errors++;
                $display("FAIL single_result: got %h expected 08", wr_dat[w0]);
            end
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
            errors++;
            $display("FAIL single_alu_inputs: got %h %h %h expected 05 03 20", alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_backpressure();
        int w0 = wr_cyc.size();
        int drop_cyc;
        tick();
        tx_full = 1'b1;
        push(8'h0F); push(8'hF0); push(8'h25);
        repeat (14) tick();
        checks++;
        if (wr_cyc.size() != w0) begin
            errors++;
            $display("FAIL bp_held: got %0d writes expected 0 while tx_full", wr_cyc.size() - w0);
        end
        tick();
        tx_full = 1'b0;
        drop_cyc = cyc;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (wr_cyc.size() != w0 + 1) begin
            errors++;
            $display("FAIL bp_write_count: got %0d expected 1", wr_cyc.size() - w0);
        end else begin
            checks++;
            if (wr_cyc[w0] != drop_cyc || wr_dat[w0] !== 8'hFF) begin
                errors++;
                $display("FAIL bp_release: got cycle %0d data %h expected cycle %0d data ff", wr_cyc[w0], wr_dat[w0], drop_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cyc.size();
        tick();
        push(8'h09); push(8'h04); push(8'h22);
        push(8'h80); push(8'h01); push(8'h02);
        wait_writes(w0 + 2, 60, "b2b");
        if (wr_cyc.size() >= w0 + 2) begin
            checks++;
            if (wr_dat[w0] !== 8'h05 || wr_dat[w0+1] !== 8'h40) begin
                errors++;
                $display("FAIL b2b_results: got %h %h expected 05 40", wr_dat[w0], wr_dat[w0+1]);
            end
            checks++;
            if (wr_cyc[w0+1] - wr_cyc[w0] != 5) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d expected 5", wr_cyc[w0+1] - wr_cyc[w0]);
            end
        end
    endtask

    task automatic test_opmask();
        int w0 = wr_cyc.size();
        tick();
        push(8'h33); push(8'h11); push(8'hE0);
        wait_writes(w0 + 1, 40, "opmask");
        checks++;
        if (alu_op !== 6'h20) begin
            errors++;
            $display("FAIL opmask_op: got %h expected 20", alu_op);
        end
        if (wr_dat.size() > w0) begin
            checks++;
            if (wr_dat[w0] !== 8'h44) begin
                errors++;
                $display("FAIL opmask_result: got %h expected 44", wr_dat[w0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0 = rd_cyc.size();
        int w0 = wr_cyc.size();
        int k = 0;
        tick();
        push(8'h11); push(8'h22);
        while (rd_cyc.size() < n0 + 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        tick();
        reset = 1'b1;
        push(8'h07); push(8'h02); push(8'h22);
        @(negedge clk);
        checks++;
        if (rd_uart !== 1'b0 || wr_uart !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_strobe: got rd=%b wr=%b expected 0 0", rd_uart, wr_uart);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_op, w_data, busy} !== 31'h0) begin
            errors++;
            $display("FAIL rst_mid_regs: got a=%h b=%h op=%h w=%h busy=%b expected 0", alu_a, alu_b, alu_op, w_data, busy);
        end
        wait_writes(w0 + 1, 40, "rst_mid");
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cyc.size() != w0 + 1) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d writes expected 1", wr_cyc.size() - w0);
        end else begin
            checks++;
            if (wr_dat[w0] !== 8'h05) begin
                errors++;
                $display("FAIL rst_mid_result: got %h expected 05", wr_dat[w0]);
            end
        end
    endtask

    task automatic test_timeout();
        int n0 = rd_cyc.size();
        int w0 = wr_cyc.size();
        int t0 = to_cyc.size();
        tick();
        push(8'h05);
        repeat (TCYC + 30) @(negedge clk);
`ifdef ALU_IF_TIMEOUT_EN
        checks++;
        if (to_cyc.size() - t0 != 1 || rd_cyc.size() <= n0) begin
            errors++;
            $display("FAIL to_pulse_count: got %0d expected 1", to_cyc.size() - t0);
        end else begin
            checks++;
            if (to_cyc[t0] != rd_cyc[n0] + TCYC) begin
                errors++;
                $display("FAIL to_pulse_cycle: got %0d expected %0d", to_cyc[t0], rd_cyc[n0] + TCYC);
            end
        end
        checks++;
        if (busy !== 1'b0 || alu_a !== 8'h05 || wr_cyc.size() != w0) begin
            errors++;
            $display("FAIL to_state: got busy=%b a=%h writes=%0d expected 0 05 0", busy, alu_a, wr_cyc.size() - w0);
        end
        tick();
        push(8'h07); push(8'h02); push(8'h22);
        wait_writes(w0 + 1, 40, "to_next");
        if (wr_dat.size() > w0) begin
            checks++;
            if (wr_dat[w0] !== 8'h05) begin
                errors++;
                $display("FAIL to_next_result: got %h expected 05", wr_dat[w0]);
            end
        end
`else
        checks++;
        if (to_cyc.size() != t0 || busy !== 1'b1 || wr_cyc.size() != w0) begin
            errors++;
            $display("FAIL no_to_wait: got pulses=%0d busy=%b writes=%0d expected 0 1 0", to_cyc.size() - t0, busy, wr_cyc.size() - w0);
        end
        tick();
        push(8'h02); push(8'h22);
        wait_writes(w0 + 1, 40, "no_to_next");
        if (wr_dat.size() > w0) begin
            checks++;
            if (wr_dat[w0] !== 8'h03) begin
                errors++;
                $display("FAIL no_to_result: got %h expected 03", wr_dat[w0]);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [5:0] ops[8] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        logic [7:0] bytes[$];
        logic [7:0] exp[$];
        int w0 = wr_cyc.size();
        int k = 0;
        for (int f = 0; f < 25; f++) begin
            logic [7:0] a, b, opb;
            a   = 8'($urandom);
            b   = 8'($urandom_range(0, 9));
            opb = {2'($urandom), ops[$urandom_range(0, 7)]};
            bytes.push_back(a); bytes.push_back(b); bytes.push_back(opb);
            exp.push_back(alu_model(a, b, opb[5:0]));
        end
        while ((bytes.size() > 0 || wr_cyc.size() < w0 + 25) && k < 3000) begin
            tick();
            tx_full = ($urandom_range(0, 3) == 0);
            if (bytes.size() > 0 && $urandom_range(0, 1) == 1) push(bytes.pop_front());
            k++;
        end
        tx_full = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (wr_cyc.size() != w0 + 25) begin
            errors++;
            $display("FAIL rand_count: got %0d writes expected 25", wr_cyc.size() - w0);
        end else begin
            for (int i = 0; i < 25; i++) begin
                checks++;
                if (wr_dat[w0+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got %h expected %h", i, wr_dat[w0+i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_backpressure();
        test_back_to_back();
        test_opmask();
        test_reset_mid_frame();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
